// File: rtl/pwm_capture_if.sv
// Result bus of the PWM capture block: measured counts, duty code and status flags.
// Latency: carries registered values only; no logic of its own.
// Backpressure: none; valid is a one-cycle pulse and consumers must take it when it is seen.
//
// Signals:
//   duty_cycle  [7:0]    last duty code, min(high_cnt, 255); 0/255 on a stuck event
//   high_cnt    [CW-1:0] last measured high time in clk cycles
//   period_cnt  [CW-1:0] last measured rise-to-rise period in clk cycles
//   valid                one-cycle pulse whenever the fields above update
//   locked               at least one full period measured since reset/stuck
//   stuck_low            input held low for the timeout window
//   stuck_high           input held high for the timeout window
interface pwm_capture_if #(
   parameter int CW = 16
);
   logic [7:0]    duty_cycle;
   logic [CW-1:0] high_cnt;
   logic [CW-1:0] period_cnt;
   logic          valid;
   logic          locked;
   logic          stuck_low;
   logic          stuck_high;

   modport master (
      output duty_cycle, high_cnt, period_cnt, valid, locked, stuck_low, stuck_high
   );

   modport slave (
      input  duty_cycle, high_cnt, period_cnt, valid, locked, stuck_low, stuck_high
   );
endinterface

// File: rtl/pwm_capture.sv
// PWM input decoder: measures high time and rise-to-rise period, reports an 8-bit duty code, flags stuck input.
// Latency: a pwm_in transition shows as an edge pulse SYNC_STAGES+1 cycles later; results register the cycle after the rise.
// Backpressure: none; results are published with a one-cycle valid pulse and overwritten by the next measurement.
//
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   pwm_in  PWM waveform, asynchronous to clk
//   res     result bus (pwm_capture_if.master): duty_cycle, high_cnt, period_cnt, valid, locked, stuck_low, stuck_high
module pwm_capture #(
   parameter int CW          = 16,
   parameter int TIMEOUT     = 1024,
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           pwm_in,
   pwm_capture_if.master  res
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   // One spare bit so TIMEOUT-1 always fits and the counter can run past it.
   localparam int TW = $clog2(TIMEOUT) + 1;

   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [TW-1:0] TCNT_MAX = '1;
   localparam logic [TW-1:0] TCNT_TO  = TW'(TIMEOUT - 1);
   localparam logic [CW-1:0] DUTY_SAT = CW'(255);

   // ------------------------------------------------------------------
   // Input synchroniser and edge detection
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   pwm_s;
   logic                   pwm_d;
   logic                   rise;
   logic                   fall;
   logic                   edge_any;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         pwm_d  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         pwm_d  <= pwm_s;
      end
   end

   assign pwm_s    = sync_q[SYNC_STAGES-1];
   assign rise     = pwm_s & ~pwm_d;
   assign fall     = ~pwm_s & pwm_d;
   assign edge_any = rise | fall;

   // ------------------------------------------------------------------
   // State and registered results
   // ------------------------------------------------------------------
   state_t        state,      state_n;
   logic [CW-1:0] hcnt,       hcnt_n;
   logic [CW-1:0] pcnt,       pcnt_n;
   logic [TW-1:0] tcnt,       tcnt_n;
   logic [7:0]    duty_q,     duty_n;
   logic [CW-1:0] high_q,     high_n;
   logic [CW-1:0] period_q,   period_n;
   logic          valid_q,    valid_n;
   logic          locked_q,   locked_n;
   logic          stk_low_q,  stk_low_n;
   logic          stk_high_q, stk_high_n;
   logic          timeout;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + CW'(1);
   endfunction

   function automatic logic [7:0] duty_code(input logic [CW-1:0] h);
      return (h > DUTY_SAT) ? 8'hFF : h[7:0];
   endfunction

   // The compare matches only once per quiet stretch because tcnt keeps
   // counting past TIMEOUT-1, so a stuck event publishes exactly one valid.
   // An edge in the same cycle clears tcnt instead and suppresses the event.
   assign timeout = ~edge_any && (tcnt == TCNT_TO) && ~stk_low_q && ~stk_high_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hcnt       <= '0;
         pcnt       <= '0;
         tcnt       <= '0;
         duty_q     <= '0;
         high_q     <= '0;
         period_q   <= '0;
         valid_q    <= 1'b0;
         locked_q   <= 1'b0;
         stk_low_q  <= 1'b0;
         stk_high_q <= 1'b0;
      end else begin
         state      <= state_n;
         hcnt       <= hcnt_n;
         pcnt       <= pcnt_n;
         tcnt       <= tcnt_n;
         duty_q     <= duty_n;
         high_q     <= high_n;
         period_q   <= period_n;
         valid_q    <= valid_n;
         locked_q   <= locked_n;
         stk_low_q  <= stk_low_n;
         stk_high_q <= stk_high_n;
      end
   end

   always_comb begin
      state_n    = state;
      hcnt_n     = hcnt;
      pcnt_n     = pcnt;
      duty_n     = duty_q;
      high_n     = high_q;
      period_n   = period_q;
      valid_n    = 1'b0;
      locked_n   = locked_q;
      stk_low_n  = stk_low_q;
      stk_high_n = stk_high_q;

      // Quiet-time counter for stuck detection.
      if (edge_any) begin
         tcnt_n = '0;
      end else if (tcnt == TCNT_MAX) begin
         tcnt_n = tcnt;
      end else begin
         tcnt_n = tcnt + TW'(1);
      end

      // Any edge proves the input is alive again.
      if (edge_any) begin
         stk_low_n  = 1'b0;
         stk_high_n = 1'b0;
      end

      case (state)
         IDLE: begin
            if (rise) begin
               hcnt_n  = CW'(1);
               pcnt_n  = CW'(1);
               state_n = HIGH;
            end
         end

         HIGH: begin
            pcnt_n = sat_inc(pcnt);
            if (fall) begin
               state_n = LOW;
            end else begin
               hcnt_n = sat_inc(hcnt);
            end
         end

         LOW: begin
            if (rise) begin
               high_n   = hcnt;
               period_n = pcnt;
               duty_n   = duty_code(hcnt);
               valid_n  = 1'b1;
               locked_n = 1'b1;
               hcnt_n   = CW'(1);
               pcnt_n   = CW'(1);
               state_n  = HIGH;
            end else begin
               pcnt_n = sat_inc(pcnt);
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase

      // timeout implies no edge this cycle, so it never collides with a
      // publish above; it simply overrides the counting branches.
      if (timeout) begin
         high_n     = '0;
         period_n   = '0;
         valid_n    = 1'b1;
         locked_n   = 1'b0;
         hcnt_n     = '0;
         pcnt_n     = '0;
         state_n    = IDLE;
         if (pwm_s) begin
            stk_high_n = 1'b1;
            duty_n     = 8'hFF;
         end else begin
            stk_low_n  = 1'b1;
            duty_n     = 8'h00;
         end
      end
   end

   assign res.duty_cycle = duty_q;
   assign res.high_cnt   = high_q;
   assign res.period_cnt = period_q;
   assign res.valid      = valid_q;
   assign res.locked     = locked_q;
   assign res.stuck_low  = stk_low_q;
   assign res.stuck_high = stk_high_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: drives generator-style PWM periods from a table and checks each published measurement.
// Latency: a result is expected during the period that follows the one being measured.
// Backpressure: none; a negedge monitor records every valid pulse.
module tb_pwm_capture;

   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pwm_in = 1'b0;

   pwm_capture_if #(.CW(CW)) bus ();

   pwm_capture #(
      .CW          (CW),
      .TIMEOUT     (1024),
      .SYNC_STAGES (2)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .pwm_in (pwm_in),
      .res    (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: snapshot of the last valid pulse.
   int valid_cnt  = 0;
   int cap_high   = -1;
   int cap_period = -1;
   int cap_duty   = -1;
   int cap_sl     = -1;
   int cap_sh     = -1;
   int stuck_cyc  = -1;

   always @(negedge clk) begin
      if (bus.valid === 1'b1) begin
         valid_cnt  = valid_cnt + 1;
         cap_high   = int'(bus.high_cnt);
         cap_period = int'(bus.period_cnt);
         cap_duty   = int'(bus.duty_cycle);
         cap_sl     = int'(bus.stuck_low);
         cap_sh     = int'(bus.stuck_high);
         if (bus.stuck_low === 1'b1 || bus.stuck_high === 1'b1) stuck_cyc = cyc;
      end
   end

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   int last_chg = 0;

   task automatic drive_cycles(input logic v, input int n);
      for (int c = 0; c < n; c++) begin
         if (pwm_in !== v) last_chg = cyc;
         pwm_in = v;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_period(input int h, input int p);
      drive_cycles(1'b1, h);
      drive_cycles(1'b0, p - h);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " duty"},   int'(bus.duty_cycle), 0);
      chk({tag, " high"},   int'(bus.high_cnt),   0);
      chk({tag, " period"}, int'(bus.period_cnt), 0);
      chk({tag, " valid"},  int'(bus.valid),      0);
      chk({tag, " locked"}, int'(bus.locked),     0);
      chk({tag, " slow"},   int'(bus.stuck_low),  0);
      chk({tag, " shigh"},  int'(bus.stuck_high), 0);
   endtask

   // One generator period per record; exp_* is the measurement expected to
   // be published during that record (i.e. of the previous record's period).
   typedef struct {
      int high;
      int period;
      int exp_vld;
      int exp_high;
      int exp_period;
      int exp_duty;
      int exp_locked;
   } vec_t;

   // Stuck pulse lands 1027 edges after the pwm_in change: 2 sync edges,
   // 1 edge to clear tcnt, 1023 edges to reach TIMEOUT-1, 1 edge to register.
   localparam int STUCK_LAT = 1027;

   vec_t vt[9];
   int   v0;

   initial begin
      vt[0] = '{50,  256, 0,   0,   0,   0, 0};  // first rise only starts a measurement
      vt[1] = '{50,  256, 1,  50, 256,  50, 1};
      vt[2] = '{50,  256, 1,  50, 256,  50, 1};  // repeats every period
      vt[3] = '{128, 256, 1,  50, 256,  50, 1};
      vt[4] = '{200, 256, 1, 128, 256, 128, 1};
      vt[5] = '{30,  256, 1, 200, 256, 200, 1};
      vt[6] = '{400, 600, 1,  30, 256,  30, 1};
      vt[7] = '{1,   256, 1, 400, 600, 255, 1};  // long period, duty code saturates
      vt[8] = '{50,  256, 1,   1, 256,   1, 1};  // one-cycle glitch measured as 1

      // Reset for two edges with input low.
      rst = 1'b1;
      pwm_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Table-driven steady duty, sweep, long period and glitch.
      for (int i = 0; i < 9; i++) begin
         v0 = valid_cnt;
         drive_period(vt[i].high, vt[i].period);
         chk($sformatf("v%0d vld_cnt", i), valid_cnt - v0, vt[i].exp_vld);
         if (vt[i].exp_vld != 0) begin
            chk($sformatf("v%0d high",   i), cap_high,   vt[i].exp_high);
            chk($sformatf("v%0d period", i), cap_period, vt[i].exp_period);
            chk($sformatf("v%0d duty",   i), cap_duty,   vt[i].exp_duty);
         end
         chk($sformatf("v%0d locked", i), int'(bus.locked),     vt[i].exp_locked);
         chk($sformatf("v%0d slow",   i), int'(bus.stuck_low),  0);
         chk($sformatf("v%0d shigh",  i), int'(bus.stuck_high), 0);
      end

      // Stuck low: input stays low after the last fall.
      v0 = valid_cnt;
      drive_cycles(1'b0, 1100);
      chk("slow vld_cnt", valid_cnt - v0, 1);
      chk("slow flag",    cap_sl,     1);
      chk("slow duty",    cap_duty,   0);
      chk("slow high",    cap_high,   0);
      chk("slow period",  cap_period, 0);
      chk("slow locked",  int'(bus.locked), 0);
      chk("slow latency", stuck_cyc - last_chg, STUCK_LAT);
      chk("slow held",    int'(bus.stuck_low), 1);

      // Recovery: rise clears the flag, measurement one period later.
      v0 = valid_cnt;
      drive_period(50, 256);
      chk("rec1 slow",    int'(bus.stuck_low), 0);
      chk("rec1 vld_cnt", valid_cnt - v0, 0);
      v0 = valid_cnt;
      drive_period(50, 256);
      chk("rec2 vld_cnt", valid_cnt - v0, 1);
      chk("rec2 high",    cap_high,   50);
      chk("rec2 period",  cap_period, 256);
      chk("rec2 duty",    cap_duty,   50);
      chk("rec2 locked",  int'(bus.locked), 1);

      // Stuck high: the rise publishes the last period, then timeout.
      drive_cycles(1'b1, 10);
      chk("shigh pre_duty", cap_duty, 50);
      v0 = valid_cnt;
      drive_cycles(1'b1, 1090);
      chk("shigh vld_cnt", valid_cnt - v0, 1);
      chk("shigh flag",    cap_sh,     1);
      chk("shigh duty",    cap_duty,   255);
      chk("shigh high",    cap_high,   0);
      chk("shigh period",  cap_period, 0);
      chk("shigh locked",  int'(bus.locked), 0);
      chk("shigh latency", stuck_cyc - last_chg, STUCK_LAT);

      // Fall clears the flag only; block stays idle.
      v0 = valid_cnt;
      drive_cycles(1'b0, 20);
      chk("fall shigh",   int'(bus.stuck_high), 0);
      chk("fall vld_cnt", valid_cnt - v0, 0);
      drive_period(50, 256);
      chk("fall idle vld", valid_cnt - v0, 0);
      drive_period(50, 256);
      chk("fall rec vld",  valid_cnt - v0, 1);
      chk("fall rec high", cap_high, 50);
      chk("fall locked",   int'(bus.locked), 1);

      // Reset in the middle of a high phase (hcnt around 20).
      drive_cycles(1'b1, 22);
      rst = 1'b1;
      drive_cycles(1'b0, 2);
      @(negedge clk);
      chk_all_zero("midrst");
      rst = 1'b0;
      @(posedge clk);
      #1;
      v0 = valid_cnt;
      drive_period(60, 300);
      chk("post1 vld_cnt", valid_cnt - v0, 0);
      drive_period(60, 300);
      chk("post2 vld_cnt", valid_cnt - v0, 1);
      chk("post2 high",    cap_high,   60);
      chk("post2 period",  cap_period, 300);
      chk("post2 duty",    cap_duty,   60);
      chk("post2 locked",  int'(bus.locked), 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the 8-bit PWM generator. It samples a PWM waveform, measures the high time and the period between successive rising edges, and reports an 8-bit duty code.
- The duty code is directly comparable with the generator's duty_cycle input.
- Used as a loopback checker on the generator output and as a general PWM input decoder.
- Detects a stuck-low or stuck-high input with a timeout.

Parameters:
- CW, 16: width of the high-time and period counters; counters saturate at 2^CW-1.
- TIMEOUT, 1024: cycles without any edge on the synchronised input before a stuck condition is declared.
- SYNC_STAGES, 2: synchroniser depth on pwm_in; legal values 2..3.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pwm_in  input  1  PWM waveform, asynchronous to clk.
- duty_cycle  output  8  last measured duty code: min(high_cnt, 255).
- high_cnt  output  CW  last measured high time, in clk cycles.
- period_cnt  output  CW  last measured period, rising edge to rising edge, in clk cycles.
- valid  output  1  one-cycle pulse whenever the result outputs update.
- locked  output  1  high while at least one complete period has been measured since the last reset or stuck event.
- stuck_low  output  1  input has been held low for TIMEOUT cycles.
- stuck_high  output  1  input has been held high for TIMEOUT cycles.

Behaviour:
- Reset:
  - rst sampled high on a clk edge clears all outputs to 0, all counters to 0 and the synchroniser flops to 0.
  - State goes to IDLE.
  - Reset is honoured in any state, including mid-measurement; partial counts are discarded.
- Input conditioning and edge detection:
  - pwm_s is pwm_in after SYNC_STAGES flops; pwm_d is pwm_s delayed one cycle.
  - rise = pwm_s & ~pwm_d; fall = ~pwm_s & pwm_d.
  - Latency from a pwm_in transition to its edge pulse is SYNC_STAGES+1 cycles.
- State machine (IDLE, HIGH, LOW):
  - IDLE: wait for rise. On rise, load hcnt=1 and pcnt=1, then go to HIGH.
  - HIGH: each cycle, hcnt++ and pcnt++ (both saturating). On fall, go to LOW; pcnt++ in that cycle, hcnt unchanged.
  - LOW: each cycle, pcnt++. On rise:
    - publish high_cnt=hcnt, period_cnt=pcnt, duty_cycle=min(hcnt,255);
    - pulse valid for 1 cycle and set locked;
    - reload hcnt=1, pcnt=1 and go to HIGH.
  - Outputs are registered and change in the cycle after the rise is detected; valid asserts in that same cycle.
- Duty-code meaning:
  - With the generator's 256-cycle period, duty_cycle equals the generator duty input for inputs 1..255.
  - A high time above 255 saturates the code to 255.
  - high_cnt and period_cnt always report the true counts, clipped only by CW saturation.
- Timeout:
  - Idle counter tcnt resets to 0 on any rise or fall and otherwise increments, saturating.
  - When tcnt reaches TIMEOUT-1 without an edge, then in the next cycle:
    - if pwm_s=0: stuck_low=1, duty_cycle=0, high_cnt=0, period_cnt=0;
    - if pwm_s=1: stuck_high=1, duty_cycle=255, high_cnt=0, period_cnt=0;
    - in both cases valid pulses once, locked=0, and state goes to IDLE.
  - The stuck flag holds until the next rise or fall, which clears it in the cycle after the edge pulse.
  - No further valid pulses occur while stuck.
- Recovery from stuck:
  - A rise starts a fresh measurement in IDLE.
  - A fall only clears the flag; the block stays in IDLE.
- Simultaneous events:
  - rst has priority over everything.
  - A timeout and an edge in the same cycle: the edge wins and no stuck event occurs.
- Glitches:
  - A one-cycle high pulse gives hcnt=1. Such pulses are measured, not filtered.

Test Plan:
- Reset and steady duty: hold rst for 2 cycles with pwm_in=0, then drive a generator-style waveform, period 256, duty 50. Required: all outputs 0 during reset; first valid after the second rise; high_cnt=50, period_cnt=256, duty_cycle=50, locked=1; valid repeats every 256 cycles.
- Duty sweep: change generator duty 50 -> 128 -> 200 -> 30. Required: after each change, the first full period reports the new value, 128, 200 then 30 in turn, with period_cnt=256 throughout.
- Stuck low: drive duty 0, input constant low, for 1100 cycles after lock. Required: 1024 cycles after the last edge (TIMEOUT), valid pulses once with stuck_low=1, duty_cycle=0, locked=0. A later rise clears stuck_low and produces a valid measurement one period later.
- Stuck high: hold pwm_in high for 1100 cycles. Required: stuck_high=1, duty_cycle=255 and a single valid pulse. The next fall clears the flag.
- Long period and saturation: period 600 with high time 400. Required: high_cnt=400, period_cnt=600, duty_cycle=255.
- Reset mid-measurement: assert rst while in HIGH with hcnt=20. Required: all outputs 0 and state IDLE; the next complete period after release reports correct counts and no stale values.
